// File: rtl/cdc_handshake_tx.sv
// Source-side end of a two-phase toggle handshake: holds a word on dataOut,
// flips reqOut, and waits for the resynchronized acknowledge toggle to match.
module cdc_handshake_tx #(
    parameter int WIDTH      = 8,
    parameter int SYNC_DEPTH = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             validIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic             readyOut,
    output logic [WIDTH-1:0] dataOut,
    output logic             reqOut,
    input  logic             ackIn,
    output logic             doneOut,
    output logic             busyOut,
    output logic             errorOut
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    if (WIDTH < 1) begin : g_badWidth
        $fatal(1, "cdc_handshake_tx: WIDTH must be at least 1");
    end
    if (SYNC_DEPTH < 2) begin : g_badSyncDepth
        $fatal(1, "cdc_handshake_tx: SYNC_DEPTH must be at least 2");
    end

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } txState_t;

    txState_t         r_state;
    (* shreg_extract = "no" *) logic [SYNC_DEPTH-1:0] r_ackSync;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_req;
    logic             r_ready;
    logic             r_done;
    logic             r_busy;
    logic             r_error;

    logic w_ackSync;
    logic w_accept;

    assign w_ackSync = r_ackSync[SYNC_DEPTH-1];
    assign w_accept  = validIn && r_ready;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            r_state   <= IDLE;
            r_ackSync <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_req     <= 1'b0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_ackSync <= {r_ackSync[SYNC_DEPTH-2:0], ackIn};
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    // An acknowledge edge with no request outstanding means the far side lost parity.
                    if (w_ackSync != r_req) begin
                        r_error <= 1'b1;
                    end
                    if (w_accept) begin
                        r_data  <= dataIn;
                        r_req   <= ~r_req;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (w_ackSync == r_req) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        // Timeout only flags the fault; re-toggling would break toggle parity.
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
                        if ((TIMEOUT != 0) && (r_count == CNT_LAST)) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign readyOut = r_ready;
    assign dataOut  = r_data;
    assign reqOut   = r_req;
    assign doneOut  = r_done;
    assign busyOut  = r_busy;
    assign errorOut = r_error;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with SYNC_DEPTH=2 and TIMEOUT=16;
// expected values are hand-derived from the handshake timing.
module tb_cdc_handshake_tx;

    logic       clkIn = 1'b0;
    logic       rstIn;
    logic       validIn;
    logic [7:0] dataIn;
    logic       readyOut;
    logic [7:0] dataOut;
    logic       reqOut;
    logic       ackIn;
    logic       doneOut;
    logic       busyOut;
    logic       errorOut;

    int assertCount = 0;
    int failCount   = 0;

    cdc_handshake_tx #(
        .WIDTH      (8),
        .SYNC_DEPTH (2),
        .TIMEOUT    (16)
    ) dut (
        .clkIn    (clkIn),
        .rstIn    (rstIn),
        .validIn  (validIn),
        .dataIn   (dataIn),
        .readyOut (readyOut),
        .dataOut  (dataOut),
        .reqOut   (reqOut),
        .ackIn    (ackIn),
        .doneOut  (doneOut),
        .busyOut  (busyOut),
        .errorOut (errorOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic rdy, input logic [7:0] dat,
                            input logic req, input logic dne, input logic bsy, input logic err);
        check({tag, ".ready"}, 32'(readyOut), 32'(rdy));
        check({tag, ".data"},  32'(dataOut),  32'(dat));
        check({tag, ".req"},   32'(reqOut),   32'(req));
        check({tag, ".done"},  32'(doneOut),  32'(dne));
        check({tag, ".busy"},  32'(busyOut),  32'(bsy));
        check({tag, ".error"}, 32'(errorOut), 32'(err));
    endtask

    initial begin
        int   toggles;
        int   dones;
        logic prevReq;
        logic reqHist0;
        logic reqHist1;

        rstIn   = 1'b1;
        validIn = 1'b0;
        dataIn  = 8'h00;
        ackIn   = 1'b0;
        repeat (3) tick();
        checkAll("inReset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rstIn = 1'b0;
        tick();
        checkAll("afterRelease", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single transfer of 0xA5; junk 0xFF offered while waiting must be ignored.
        validIn = 1'b1;
        dataIn  = 8'hA5;
        tick();
        checkAll("accept", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        dataIn = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll("waitIgnore", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        ackIn = 1'b1;
        tick();
        check("ackEdge1.done", 32'(doneOut), 32'(1'b0));
        tick();
        check("ackEdge2.done", 32'(doneOut), 32'(1'b0));
        tick();
        checkAll("ackEdge3", 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        validIn = 1'b0;
        tick();
        checkAll("afterDone", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back words 1..4 with an ack model echoing reqOut two cycles later.
        toggles  = 0;
        dones    = 0;
        prevReq  = 1'b1;
        reqHist0 = 1'b1;
        reqHist1 = 1'b1;
        dataIn   = 8'h01;
        validIn  = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            tick();
            if (reqOut !== prevReq) begin
                toggles++;
                prevReq = reqOut;
                check("b2bWord", 32'(dataOut), 32'(toggles));
                if (toggles < 4) dataIn = 8'(toggles + 1);
                else validIn = 1'b0;
            end else if (busyOut === 1'b1 && toggles > 0) begin
                check("b2bHold", 32'(dataOut), 32'(toggles));
            end
            if (doneOut === 1'b1) dones++;
            ackIn    = reqHist1;
            reqHist1 = reqHist0;
            reqHist0 = reqOut;
        end
        check("b2bToggles", 32'(toggles), 32'd4);
        check("b2bDones",   32'(dones),   32'd4);
        checkAll("b2bEnd", 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);

        // Timeout with TIMEOUT=16, then a late acknowledge.
        validIn = 1'b1;
        dataIn  = 8'h3C;
        tick();
        checkAll("toAccept", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        validIn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("toBefore.error", 32'(errorOut), 32'(1'b0));
        end
        tick();
        checkAll("toHit", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll("toSticky", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        ackIn = 1'b0;
        repeat (2) tick();
        check("lateAck2.done", 32'(doneOut), 32'(1'b0));
        tick();
        checkAll("lateAckDone", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkAll("lateAckAfter", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset clears the sticky error.
        rstIn = 1'b1;
        tick();
        checkAll("errReset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rstIn = 1'b0;
        tick();
        checkAll("errRelease", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Spurious acknowledge toggle while idle.
        ackIn = 1'b1;
        repeat (2) tick();
        check("spur2.error", 32'(errorOut), 32'(1'b0));
        tick();
        checkAll("spurious", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        rstIn = 1'b1;
        ackIn = 1'b0;
        tick();
        rstIn = 1'b0;
        repeat (3) tick();
        checkAll("spurCleared", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of WAIT_ACK.
        validIn = 1'b1;
        dataIn  = 8'h77;
        tick();
        checkAll("midAccept", 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
        validIn = 1'b0;
        repeat (2) tick();
        rstIn = 1'b1;
        tick();
        checkAll("midReset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rstIn = 1'b0;
        tick();
        checkAll("midRelease", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
